// File: rtl/edge_scan_ctrl.sv
// Purpose: frame scanner for a 3x3 filter. It reads the nine kernel taps of each output pixel over Avalon-MM, waits for the filter result, then writes it.
// Latency: per interior pixel 9 x (read + return) cycles, then the result wait, then one write; waitrequest adds stall cycles.
// Backpressure: avm_waitrequest_i holds the current read/write with a stable address and data. One read is outstanding at most. Optional macro: EDGE_SCAN_ZERO_BORDER_EN.
module edge_scan_ctrl #(
    parameter int          IMG_W    = 8,
    parameter int          IMG_H    = 8,
    parameter int          ADDR_W   = 16,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 16'h1000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [7:0]        avm_writedata_o,
    input  logic              avm_waitrequest_i,
    input  logic [7:0]        avm_readdata_i,
    input  logic              avm_readdatavalid_i,
    output logic [7:0]        tap_o,
    output logic [3:0]        tap_idx_o,
    output logic              tap_valid_o,
    input  logic [7:0]        result_i,
    input  logic              result_valid_i
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_REQ   = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_RES_WAIT = 3'd3;
    localparam logic [2:0] S_WR_REQ   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

`ifdef EDGE_SCAN_ZERO_BORDER_EN
    // Full-frame scan; border pixels are written as 0 without reading taps
    localparam bit            BORDER_EN = 1'b1;
    localparam logic [RW-1:0] R_FIRST   = '0;
    localparam logic [RW-1:0] R_LAST    = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_FIRST   = '0;
    localparam logic [CW-1:0] C_LAST    = CW'(IMG_W - 1);
`else
    // Interior-only scan; the 3x3 window never leaves the image
    localparam bit            BORDER_EN = 1'b0;
    localparam logic [RW-1:0] R_FIRST   = RW'(1);
    localparam logic [RW-1:0] R_LAST    = RW'(IMG_H - 2);
    localparam logic [CW-1:0] C_FIRST   = CW'(1);
    localparam logic [CW-1:0] C_LAST    = CW'(IMG_W - 1 - 1);
`endif

    function automatic logic is_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return BORDER_EN && ((r == '0) || (r == RW'(IMG_H - 1)) ||
                             (c == '0) || (c == CW'(IMG_W - 1)));
    endfunction

    logic [2:0]        state;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [1:0]        ky;
    logic [1:0]        kx;
    logic [7:0]        wr_data;
    logic [7:0]        tap_dat;
    logic [3:0]        tap_idx;
    logic              tap_vld;

    logic              last_col;
    logic              last_pix;
    logic              last_tap;
    logic [RW-1:0]     nxt_row;
    logic [CW-1:0]     nxt_col;
    logic [3:0]        cur_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Scan position bookkeeping and tap/pixel addresses (ADDR_W wrap-around arithmetic)
    always_comb begin
        last_col = (col == C_LAST);
        last_pix = last_col && (row == R_LAST);
        last_tap = (ky == 2'd2) && (kx == 2'd2);
        nxt_col  = last_col ? C_FIRST : col + CW'(1);
        nxt_row  = last_col ? row + RW'(1) : row;
        cur_idx  = {2'b00, ky} * 4'd3 + {2'b00, kx};
        rd_addr  = ADDR_W'(SRC_BASE)
                 + (ADDR_W'(row) + ADDR_W'(ky) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                 + ADDR_W'(col) + ADDR_W'(kx) - ADDR_W'(1);
        wr_addr  = ADDR_W'(DST_BASE) + ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    end

    // Scan FSM: tap reads, result capture, result write, frame completion
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            ky      <= '0;
            kx      <= '0;
            wr_data <= '0;
            tap_dat <= '0;
            tap_idx <= '0;
            tap_vld <= 1'b0;
        end else begin
            tap_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        row     <= R_FIRST;
                        col     <= C_FIRST;
                        ky      <= '0;
                        kx      <= '0;
                        wr_data <= '0;
                        state   <= is_border(R_FIRST, C_FIRST) ? S_WR_REQ : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!avm_waitrequest_i) begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (avm_readdatavalid_i) begin
                        tap_vld <= 1'b1;
                        tap_dat <= avm_readdata_i;
                        tap_idx <= cur_idx;
                        if (last_tap) begin
                            ky    <= '0;
                            kx    <= '0;
                            state <= S_RES_WAIT;
                        end else begin
                            if (kx == 2'd2) begin
                                kx <= '0;
                                ky <= ky + 2'd1;
                            end else begin
                                kx <= kx + 2'd1;
                            end
                            state <= S_RD_REQ;
                        end
                    end
                end
                S_RES_WAIT: begin
                    if (result_valid_i) begin
                        wr_data <= result_i;
                        state   <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (!avm_waitrequest_i) begin
                        if (last_pix) begin
                            state <= S_DONE;
                        end else begin
                            row <= nxt_row;
                            col <= nxt_col;
                            if (is_border(nxt_row, nxt_col)) begin
                                wr_data <= '0;
                                state   <= S_WR_REQ;
                            end else begin
                                state <= S_RD_REQ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    row     <= '0;
                    col     <= '0;
                    ky      <= '0;
                    kx      <= '0;
                    wr_data <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from state so reset drops them in the same instant
    always_comb begin
        busy_o          = (state != S_IDLE);
        done_o          = (state == S_DONE);
        avm_read_o      = (state == S_RD_REQ);
        avm_write_o     = (state == S_WR_REQ);
        avm_address_o   = '0;
        avm_writedata_o = '0;
        if (state == S_RD_REQ) begin
            avm_address_o = rd_addr;
        end else if (state == S_WR_REQ) begin
            avm_address_o   = wr_addr;
            avm_writedata_o = wr_data;
        end
        tap_o       = tap_dat;
        tap_idx_o   = tap_idx;
        tap_valid_o = tap_vld;
    end

endmodule

// File: doc/edge_scan_ctrl.md
EDGE_SCAN_CTRL -- requirements
Module: edge_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8: image width in pixels, at least 3.
REQ-002 SHALL have parameter IMG_H, default 8: image height in pixels, at least 3.
REQ-003 SHALL have parameter ADDR_W, default 16: Avalon byte-address width.
REQ-004 SHALL have parameter SRC_BASE, default 0: source image base address.
REQ-005 SHALL have parameter DST_BASE, default 16'h1000: destination image base address.
REQ-006 SHALL have port clk_i, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start_i, input, 1: pulse that begins a frame scan.
REQ-009 SHALL have port busy_o, output, 1: high while a scan is in progress.
REQ-010 SHALL have port done_o, output, 1: one-cycle pulse when a frame completes.
REQ-011 SHALL have port avm_address_o, output, ADDR_W: Avalon-MM address.
REQ-012 SHALL have ports avm_read_o and avm_write_o, output, 1 each: Avalon-MM read and write strobes.
REQ-013 SHALL have port avm_writedata_o, output, 8: result pixel to write.
REQ-014 SHALL have port avm_waitrequest_i, input, 1: slave stall.
REQ-015 SHALL have ports avm_readdata_i, input, 8, and avm_readdatavalid_i, input, 1: returned read data.
REQ-016 SHALL have ports tap_o, output, 8; tap_idx_o, output, 4; and tap_valid_o, output, 1: kernel tap value, tap index 0..8 (row-major), and tap strobe to the filter datapath.
REQ-017 SHALL have ports result_i, input, 8, and result_valid_i, input, 1: filter output pixel and its strobe.

Function
REQ-018 SHALL implement the FSM states IDLE, RD_REQ, RD_WAIT, RES_WAIT, WR_REQ and DONE.
REQ-019 IDLE SHALL move to RD_REQ on start_i; start_i SHALL be ignored in every other state.
REQ-020 Per output pixel (r,c), SHALL read 9 taps, ky and kx each 0..2 with kx fastest, at SRC_BASE + (r+ky-1)*IMG_W + (c+kx-1).
REQ-021 RD_REQ SHALL assert avm_read_o with a stable address until a cycle with avm_waitrequest_i=0, then go to RD_WAIT.
REQ-022 SHALL keep at most one read outstanding.
REQ-023 RD_WAIT SHALL, on avm_readdatavalid_i, drive tap_valid_o=1 for exactly one cycle, the following cycle, with tap_o=readdata and tap_idx_o=ky*3+kx.
REQ-024 After tap 8, SHALL go to RES_WAIT; otherwise SHALL return to RD_REQ.
REQ-025 RES_WAIT SHALL capture result_i on result_valid_i and go to WR_REQ; result_valid_i in any other state SHALL be ignored.
REQ-026 WR_REQ SHALL assert avm_write_o at address DST_BASE + r*IMG_W + c until avm_waitrequest_i=0, holding both address and data stable.
REQ-027 After a write, the pixel scan SHALL advance c first; c SHALL wrap to its first value and r SHALL increment; after the last pixel the FSM SHALL go to DONE.
REQ-028 The default scan SHALL cover interior pixels only: r from 1 to IMG_H-2 and c from 1 to IMG_W-2.
REQ-029 DONE SHALL pulse done_o for one cycle, clear the counters and return to IDLE.
REQ-030 busy_o SHALL be 1 in every state except IDLE.
REQ-031 avm_read_o and avm_write_o SHALL never both be high.
REQ-032 Counter widths SHALL be $clog2(IMG_W) and $clog2(IMG_H); address arithmetic SHALL be ADDR_W wide, truncated with no overflow flag.

Reset
REQ-033 rst_n_i low SHALL force IDLE immediately, at any point including mid-transfer.
REQ-034 On reset, all outputs and counters SHALL be 0, and any captured result SHALL be discarded.
REQ-035 After reset release, the block SHALL need a new start_i; a stale avm_readdatavalid_i arriving in IDLE SHALL be ignored.

Configuration
REQ-036 Macro EDGE_SCAN_ZERO_BORDER_EN SHALL control border handling.
REQ-037 With EDGE_SCAN_ZERO_BORDER_EN defined, the scan SHALL cover every pixel from (0,0) to (IMG_H-1,IMG_W-1), writing 0 directly to each border pixel from WR_REQ with no reads and no tap_valid_o.
REQ-038 With EDGE_SCAN_ZERO_BORDER_EN undefined, the scan SHALL cover interior pixels only (REQ-028) and no border writes SHALL occur.

Verification
REQ-039 IMG 4x4, zero-wait slave, result = tap 4: start -> 36 reads, 4 writes at DST+5, DST+6, DST+9, DST+10, then one done_o pulse.
REQ-040 Pixel (1,1): read addresses SHALL be SRC+0,1,2,4,5,6,8,9,10; tap_idx_o SHALL be 0..8 in order.
REQ-041 waitrequest held 3 cycles on a read and on a write -> address, data and strobe stable throughout; no duplicate transfer.
REQ-042 start_i pulsed while busy, and result_valid_i pulsed in RD_WAIT -> no effect on the sequence or on the written values.
REQ-043 rst_n_i low during RD_WAIT of pixel 2 -> all outputs 0 immediately; a new start rescans from (1,1).
REQ-044 With EDGE_SCAN_ZERO_BORDER_EN and IMG 4x4 -> 16 writes, of which 12 border writes are 0, and exactly 36 reads.
